// File: rtl/decode_issue_stage.sv
// Decode/issue (ID) stage of a five-stage RV32I pipeline.
// The stage drives the register-file read addresses from the fetched
// instruction. It resolves both source operands through EX/MEM/WB
// forwarding and holds back an instruction that depends on a load still
// in EX. Accepted instructions go into the ID/EX pipeline register.
module decode_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    // fetch side
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_insn,
    // register file read port
    output logic [4:0]       addr_rs1,
    output logic [4:0]       addr_rs2,
    input  logic [XLEN-1:0]  data_rs1,
    input  logic [XLEN-1:0]  data_rs2,
    // forwarding sources
    input  logic             ex_wb_en,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             mem_wb_en,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             wb_wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    // redirect from EX
    input  logic             flush,
    // ID/EX register
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_insn,
    output logic [XLEN-1:0]  id_rs1_val,
    output logic [XLEN-1:0]  id_rs2_val,
    output logic [4:0]       id_rd,
    output logic             id_wb_en,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            load_use;
    logic            accept;

    assign opcode   = if_insn[6:0];
    assign rd       = if_insn[11:7];
    assign rs1      = if_insn[19:15];
    assign rs2      = if_insn[24:20];
    assign addr_rs1 = rs1;
    assign addr_rs2 = rs2;

    // Decode which register fields the instruction actually reads and writes.
    always_comb begin
        uses_rs1  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
        uses_rs2  = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
        writes_rd = !((opcode == OPC_BRANCH) || (opcode == OPC_STORE)) && (rd != 5'd0);
    end

    // Resolve rs1: x0 is hardwired, then youngest producer wins. A load in
    // EX has no data yet, so it is never a forwarding source.
    always_comb begin
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (ex_wb_en && !ex_is_load && (ex_rd == rs1))
            rs1_val = ex_data;
        else if (mem_wb_en && (mem_rd == rs1))
            rs1_val = mem_data;
        else if (wb_wb_en && (wb_rd == rs1))
            rs1_val = wb_data;
        else
            rs1_val = data_rs1;
    end

    // Resolve rs2 with the same priority as rs1.
    always_comb begin
        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (ex_wb_en && !ex_is_load && (ex_rd == rs2))
            rs2_val = ex_data;
        else if (mem_wb_en && (mem_rd == rs2))
            rs2_val = mem_data;
        else if (wb_wb_en && (wb_rd == rs2))
            rs2_val = wb_data;
        else
            rs2_val = data_rs2;
    end

    // A load in EX whose destination feeds a used source must wait a cycle.
    always_comb begin
        load_use = ex_wb_en && ex_is_load && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    end

    // Handshake: a transfer happens on a clock edge where valid and ready
    // are both high. valid never depends on ready in the same cycle. Once
    // id_valid is raised, the payload holds until EX takes it with id_ready.
    // if_ready opens when the ID/EX slot is empty or draining. It stays
    // closed during a load-use hazard or a flush.
    assign if_ready = (!id_valid || id_ready) && !load_use && !flush;
    assign accept   = if_valid && if_ready;

    // ID/EX pipeline register: flush kills, accept loads, drain leaves a bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_insn    <= '0;
            id_rs1_val <= '0;
            id_rs2_val <= '0;
            id_rd      <= '0;
            id_wb_en   <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid   <= 1'b1;
            id_pc      <= if_pc;
            id_insn    <= if_insn;
            id_rs1_val <= rs1_val;
            id_rs2_val <= rs2_val;
            id_rd      <= writes_rd ? rd : 5'd0;
            id_wb_en   <= writes_rd;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end
    end

    // Count cycles a valid fetch is held back by a load-use hazard, saturating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if (if_valid && load_use && !flush && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_ONE;
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a table of single-instruction
// forwarding cases followed by hand-written multi-cycle sequences
// (load-use stall, hold under backpressure, flush, counter saturation,
// asynchronous reset while stalled).
module tb_decode_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int OUT_W = 32 + 32 + 32 + 32 + 5 + 1;

    logic             clock;
    logic             reset_n;
    logic             if_valid;
    logic             if_ready;
    logic [XLEN-1:0]  if_pc;
    logic [31:0]      if_insn;
    logic [4:0]       addr_rs1;
    logic [4:0]       addr_rs2;
    logic [XLEN-1:0]  data_rs1;
    logic [XLEN-1:0]  data_rs2;
    logic             ex_wb_en;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_data;
    logic             mem_wb_en;
    logic [4:0]       mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             wb_wb_en;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [31:0]      id_insn;
    logic [XLEN-1:0]  id_rs1_val;
    logic [XLEN-1:0]  id_rs2_val;
    logic [4:0]       id_rd;
    logic             id_wb_en;
    logic [CNT_W-1:0] stall_cycles;

    decode_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_insn(if_insn),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .data_rs1(data_rs1), .data_rs2(data_rs2),
        .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wb_en(mem_wb_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wb_en(wb_wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_insn(id_insn),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_rd(id_rd), .id_wb_en(id_wb_en),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ex_en;
        logic        ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        mem_en;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [4:0]  exp_a1;
        logic [4:0]  exp_a2;
        logic [31:0] exp_r1;
        logic [31:0] exp_r2;
        logic [4:0]  exp_rd;
        logic        exp_we;
    } vec_t;

    vec_t             vt[8];
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] last_out;
    logic [CNT_W-1:0] exp_stall;
    int               total;
    int               bad;

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [OUT_W-1:0] out_bus();
        return {id_pc, id_insn, id_rs1_val, id_rs2_val, id_rd, id_wb_en};
    endfunction

    function automatic logic [OUT_W-1:0] pack_exp(input logic [31:0] pc, input logic [31:0] insn,
                                                  input logic [31:0] r1, input logic [31:0] r2,
                                                  input logic [4:0] rd, input logic we);
        return {pc, insn, r1, r2, rd, we};
    endfunction

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_fwd();
        ex_wb_en = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_data = '0;
        mem_wb_en = 1'b0; mem_rd = 5'd0; mem_data = '0;
        wb_wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        if_pc = v.pc; if_insn = v.insn; data_rs1 = v.d1; data_rs2 = v.d2;
        ex_wb_en = v.ex_en; ex_is_load = v.ex_ld; ex_rd = v.ex_rd; ex_data = v.ex_data;
        mem_wb_en = v.mem_en; mem_rd = v.mem_rd; mem_data = v.mem_data;
        wb_wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    endtask

    // Scoreboard: pop the oldest expected instruction and compare the ID/EX register.
    task automatic check_out(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got empty expected queue want entry", name);
        end else begin
            last_out = exp_q.pop_front();
            chk({name, "_valid"}, id_valid, 1'b1);
            chk({name, "_data"}, out_bus(), last_out);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_stall = '0;
        reset_n = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_insn = '0;
        data_rs1 = '0; data_rs2 = '0;
        flush = 1'b0; id_ready = 1'b0;
        clear_fwd();

        // order: pc insn d1 d2 | ex en ld rd data | mem en rd data | wb en rd data | a1 a2 r1 r2 rd we
        vt[0] = '{32'h100, 32'h00500093, 32'h11, 32'h22, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'h22, 5'd1, 1'b1};
        vt[1] = '{32'h104, 32'h002081B3, 32'hDEAD, 32'hDEAD, 1'b1, 1'b0, 5'd1, 32'h7, 1'b1, 5'd2, 32'h9,
                  1'b1, 5'd1, 32'h4, 5'd1, 5'd2, 32'h7, 32'h9, 5'd3, 1'b1};
        vt[2] = '{32'h108, 32'h002081B3, 32'hDEAD, 32'hDEAD, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h55,
                  1'b1, 5'd1, 32'h66, 5'd1, 5'd2, 32'h55, 32'hDEAD, 5'd3, 1'b1};
        vt[3] = '{32'h10C, 32'h002081B3, 32'h1111, 32'h2222, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b1, 5'd2, 32'h77, 5'd1, 5'd2, 32'h1111, 32'h77, 5'd3, 1'b1};
        vt[4] = '{32'h110, 32'h002081B3, 32'h1111, 32'h2222, 1'b0, 1'b0, 5'd1, 32'h7, 1'b0, 5'd2, 32'h9,
                  1'b0, 5'd1, 32'h4, 5'd1, 5'd2, 32'h1111, 32'h2222, 5'd3, 1'b1};
        vt[5] = '{32'h114, 32'h0020A423, 32'hA, 32'hB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 32'hA, 32'hB, 5'd0, 1'b0};
        vt[6] = '{32'h118, 32'h00208033, 32'h3, 32'h4, 1'b1, 1'b0, 5'd2, 32'h44, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 32'h3, 32'h44, 5'd0, 1'b0};
        vt[7] = '{32'h11C, 32'h000001B3, 32'h5, 32'h6, 1'b1, 1'b0, 5'd0, 32'h99, 1'b1, 5'd0, 32'h88,
                  1'b1, 5'd0, 32'h77, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 1'b1};

        // Reset values.
        repeat (2) @(negedge clock);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_fields", out_bus(), '0);
        chk("rst_stall", stall_cycles, '0);
        reset_n = 1'b1;
        @(negedge clock);

        // Table: back-to-back accepts with id_ready held high.
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_vec(vt[i]);
            if_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_if_ready", i), if_ready, 1'b1);
            chk($sformatf("v%0d_addr", i), {addr_rs1, addr_rs2}, {vt[i].exp_a1, vt[i].exp_a2});
            exp_q.push_back(pack_exp(vt[i].pc, vt[i].insn, vt[i].exp_r1, vt[i].exp_r2,
                                     vt[i].exp_rd, vt[i].exp_we));
            step();
            check_out($sformatf("v%0d", i));
        end

        // Drain with nothing new leaves a bubble.
        if_valid = 1'b0;
        clear_fwd();
        step();
        chk("drain_bubble", id_valid, 1'b0);
        chk("stall_none", stall_cycles, exp_stall);

        // Load-use: load to x5 in EX, add x6,x5,x0 waits one cycle.
        ex_wb_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; ex_data = 32'h5A;
        if_pc = 32'h200; if_insn = 32'h00028333; data_rs1 = 32'h1234; data_rs2 = 32'h9;
        if_valid = 1'b1;
        #1;
        chk("lu_if_ready", if_ready, 1'b0);
        step();
        exp_stall = 4'd1;
        chk("lu_bubble", id_valid, 1'b0);
        chk("lu_stall", stall_cycles, exp_stall);
        ex_is_load = 1'b0;
        #1;
        chk("lu_if_ready_after", if_ready, 1'b1);
        exp_q.push_back(pack_exp(32'h200, 32'h00028333, 32'h5A, 32'h0, 5'd6, 1'b1));
        step();
        check_out("lu_accept");
        chk("lu_stall_hold", stall_cycles, exp_stall);

        // lui x5 under a load to x5: rs1 field matches but is unused, no stall,
        // and the load in EX is not a forwarding source.
        ex_is_load = 1'b1;
        if_pc = 32'h204; if_insn = 32'h000282B7; data_rs1 = 32'h3333; data_rs2 = 32'h4444;
        #1;
        chk("lui_if_ready", if_ready, 1'b1);
        exp_q.push_back(pack_exp(32'h204, 32'h000282B7, 32'h3333, 32'h0, 5'd5, 1'b1));
        step();
        check_out("lui_accept");
        chk("lui_stall", stall_cycles, exp_stall);

        // Backpressure: outputs hold for 3 cycles while a new instruction waits.
        clear_fwd();
        id_ready = 1'b0;
        if_pc = 32'h208; if_insn = 32'h002081B3; data_rs1 = 32'hAA; data_rs2 = 32'hBB;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_if_ready", k), if_ready, 1'b0);
            step();
            chk($sformatf("hold%0d_valid", k), id_valid, 1'b1);
            chk($sformatf("hold%0d_data", k), out_bus(), last_out);
        end
        id_ready = 1'b1;
        #1;
        chk("hold_release_if_ready", if_ready, 1'b1);
        exp_q.push_back(pack_exp(32'h208, 32'h002081B3, 32'hAA, 32'hBB, 5'd3, 1'b1));
        step();
        check_out("hold_release");

        // Flush kills the held instruction; a concurrent hazard is not counted.
        id_ready = 1'b0;
        flush = 1'b1;
        ex_wb_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
        if_pc = 32'h20C;
        #1;
        chk("flush_if_ready", if_ready, 1'b0);
        step();
        chk("flush_valid", id_valid, 1'b0);
        chk("flush_no_stall", stall_cycles, exp_stall);

        // Refill the empty slot with EX stalled downstream.
        flush = 1'b0;
        clear_fwd();
        if_pc = 32'h20C; if_insn = 32'h00500093; data_rs1 = 32'h0; data_rs2 = 32'h22;
        exp_q.push_back(pack_exp(32'h20C, 32'h00500093, 32'h0, 32'h22, 5'd1, 1'b1));
        step();
        check_out("refill");

        // Hold a load-use hazard long enough to saturate the counter.
        ex_wb_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        if_pc = 32'h210; if_insn = 32'h00028333;
        for (int k = 0; k < 17; k++) begin
            step();
            if (exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
            chk($sformatf("sat%0d_stall", k), stall_cycles, exp_stall);
        end
        chk("sat_valid_held", id_valid, 1'b1);

        // Asynchronous reset away from any clock edge, mid-stall.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", id_valid, 1'b0);
        chk("arst_fields", out_bus(), '0);
        chk("arst_stall", stall_cycles, '0);
        @(negedge clock);
        reset_n = 1'b1;
        if_valid = 1'b0;
        clear_fwd();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- ID stage of the five-stage RV32I pipeline, sitting directly upstream of register_file's consumers and downstream of fetch.
- Drives register_file read addresses from the fetched instruction.
- Resolves operands with EX/MEM/WB forwarding and detects load-use hazards.
- Registers the result into the ID/EX pipeline register under a valid/ready handshake, with flush support and a stall counter.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of stall_cycles counter (saturating)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch holds a valid instruction
- if_ready  out  1  stage accepts fetch instruction this cycle
- if_pc  in  XLEN  instruction PC
- if_insn  in  32  instruction word
- addr_rs1  out  5  register_file rs1 address; combinational, equals if_insn[19:15]
- addr_rs2  out  5  register_file rs2 address; combinational, equals if_insn[24:20]
- data_rs1  in  XLEN  register_file rs1 data
- data_rs2  in  XLEN  register_file rs2 data
- ex_wb_en, ex_is_load  in  1 each  EX-stage instruction writes rd; it is a load
- ex_rd  in  5  EX destination
- ex_data  in  XLEN  EX ALU result
- mem_wb_en  in  1  MEM-stage instruction writes rd
- mem_rd  in  5  MEM destination
- mem_data  in  XLEN  MEM result (load data or ALU result)
- wb_wb_en  in  1  WB-stage instruction writes rd
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  WB result
- flush  in  1  redirect from EX; kill ID contents
- id_valid  out  1  ID/EX register valid
- id_ready  in  1  EX accepts ID/EX contents
- id_pc  out  XLEN  registered PC
- id_insn  out  32  registered instruction
- id_rs1_val  out  XLEN  resolved rs1 operand
- id_rs2_val  out  XLEN  resolved rs2 operand
- id_rd  out  5  destination; 0 when instruction does not write
- id_wb_en  out  1  instruction writes a nonzero rd
- stall_cycles  out  CNT_W  count of load-use stall cycles

Behaviour:
- Reset (async, reset_n=0): id_valid=0; id_pc, id_insn, id_rs1_val, id_rs2_val, id_rd, id_wb_en all 0; stall_cycles=0. Takes effect immediately, even mid-stall.
- Operand usage, decoded from opcode=if_insn[6:0]:
  - uses_rs1: all opcodes except LUI(0110111), AUIPC(0010111), JAL(1101111).
  - uses_rs2: BRANCH(1100011), STORE(0100011), OP(0110011) only.
  - writes_rd: all except BRANCH and STORE; forced 0 when rd==0.
- Forwarding, per source independently:
  - Address 0 resolves to 0.
  - Otherwise priority: EX (ex_wb_en, ex_rd match, !ex_is_load) > MEM > WB > data_rs*.
  - Forwarding is combinational; the value is captured at accept.
- load_use: ex_wb_en & ex_is_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- Handshake:
  - if_ready = (!id_valid | id_ready) & !load_use & !flush.
  - Accept = if_valid & if_ready. On accept the ID/EX register loads all fields next edge and id_valid=1.
  - If the output is drained (id_valid & id_ready) with no accept, id_valid<=0 (bubble). Data fields may hold stale values.
  - If id_valid & !id_ready, all outputs hold unchanged.
- flush: next edge id_valid<=0 regardless of id_ready/if_valid; no accept that cycle. Flush outranks reset-free events only; reset dominates all.
- stall_cycles: +1 each edge where if_valid & load_use & !flush. Saturates at all-ones; no wrap.
- Latency: one cycle from accept to id_valid. Sustains one instruction per cycle with id_ready held high.

Test Plan:
- Reset then `addi x1,x0,5` (0x00500093), if_pc=0x100, id_ready=1 → next cycle id_valid=1, id_pc=0x100, id_rd=1, id_wb_en=1, id_rs1_val=0.
- `add x3,x1,x2` with ex_rd=1, ex_data=7; mem_rd=2, mem_data=9; wb_rd=1, wb_data=4; data_rs1=data_rs2=0xDEAD → id_rs1_val=7 (EX beats WB), id_rs2_val=9.
- EX is load to x5; ID `add x6,x5,x0` → if_ready=0 for 1 cycle, bubble id_valid=0, stall_cycles=1. Next cycle ex_is_load=0 → accept.
- EX is load to x5; ID `lui x5,...` → no stall (rs1 unused), accept immediately.
- id_valid=1, id_ready=0 for 3 cycles with new if_valid → outputs stable, if_ready=0. Then id_ready=1 → next instruction loads.
- flush=1 with if_valid=1 and id_valid=1 → next cycle id_valid=0. Assert reset_n=0 mid-stall → outputs 0 asynchronously, stall_cycles=0.
